// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/halt/step controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // Fast speed divides the slow tick period by 2^SPEED_SHIFT
  localparam int SPEED_SHIFT = 2;

  // Board switch lanes, indexed into the packed switch vectors
  localparam int NUM_SW   = 4;
  localparam int SW_RUN   = 0;
  localparam int SW_STEP  = 1;
  localparam int SW_SPEED = 2;
  localparam int SW_RST   = 3;

endpackage

// File: rtl/switch_debounce.sv
// One board switch: 2-flop synchronizer, stability counter, rising-edge press pulse.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Count while the synchronized input differs from the accepted level; any
  // return to the accepted level clears the count.
  always_comb begin
    sync_d  = {sync_q[0], i_Raw};
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debounce state
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign o_Level = level_q;
  assign o_Press = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller producing a one-cycle CPU clock enable.
module cpu_run_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         TICK_DIV_LOG2   = 22,
  parameter int         RST_CYCLES      = 4,
  parameter int         BREAK_EN        = 0,
  parameter logic [7:0] BREAK_PC        = 8'hFF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  input  logic [7:0] i_Pc,
  output logic       o_Cpu_Ce,
  output logic       o_Cpu_Rst,
  output logic       o_Running,
  output logic       o_Halted_Bp
);
  import cpu_ctrl_pkg::*;

  localparam int TW = TICK_DIV_LOG2;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TW-1:0] LIM_SLOW = {TW{1'b1}};
  localparam logic [TW-1:0] LIM_FAST = LIM_SLOW >> SPEED_SHIFT;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  logic [NUM_SW-1:0] sw_raw, sw_level, sw_press;

  assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Raw   (sw_raw[g]),
      .o_Level (sw_level[g]),
      .o_Press (sw_press[g])
    );
  end

  // Speed switch is consumed as a level; the others only as press events
  logic unused_sw;
  assign unused_sw = ^{sw_press[SW_SPEED], sw_level[SW_RUN], sw_level[SW_STEP], sw_level[SW_RST]};

  state_e        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [TW-1:0] tick_lim;
  logic          ce_q, ce_d;
  logic          rst_q, rst_d;
  logic          run_q, run_d;
  logic          bp_q, bp_d;
  logic          chk_q, chk_d;
  logic          bp_hit;

  // chk_q marks the cycle after a run tick, once the CPU has moved its PC
  assign tick_lim = sw_level[SW_SPEED] ? LIM_FAST : LIM_SLOW;
  assign bp_hit   = (BREAK_EN != 0) && chk_q && (i_Pc == BREAK_PC);

  // Next state and registered outputs; priority SW4 > breakpoint > SW1 > SW2
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tick_d  = tick_q;
    ce_d    = 1'b0;
    bp_d    = bp_q;
    chk_d   = 1'b0;
    if (sw_press[SW_RST]) begin
      state_d = S_RST;
      rcnt_d  = '0;
      tick_d  = '0;
    end else begin
      case (state_q)
        S_RST: begin
          if (rcnt_q == RST_LAST) begin
            state_d = S_HALT;
            rcnt_d  = '0;
            tick_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        S_HALT: begin
          if (sw_press[SW_RUN]) begin
            state_d = S_RUN;
            bp_d    = 1'b0;
            tick_d  = '0;
          end else if (sw_press[SW_STEP]) begin
            ce_d = 1'b1;
          end
        end
        S_RUN: begin
          if (bp_hit) begin
            state_d = S_HALT;
            bp_d    = 1'b1;
            tick_d  = '0;
          end else if (sw_press[SW_RUN]) begin
            state_d = S_HALT;
            tick_d  = '0;
          end else begin
            chk_d = ce_q;
            // >= so a switch to fast speed fires at once if already past the limit
            if (tick_q >= tick_lim) begin
              ce_d   = 1'b1;
              tick_d = '0;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        default: state_d = S_RST;
      endcase
    end
    rst_d = (state_d == S_RST);
    run_d = (state_d == S_RUN);
  end

  // Controller state and output registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_RST;
      rcnt_q  <= '0;
      tick_q  <= '0;
      ce_q    <= 1'b0;
      rst_q   <= 1'b1;
      run_q   <= 1'b0;
      bp_q    <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      tick_q  <= tick_d;
      ce_q    <= ce_d;
      rst_q   <= rst_d;
      run_q   <= run_d;
      bp_q    <= bp_d;
      chk_q   <= chk_d;
    end
  end

  assign o_Cpu_Ce    = ce_q;
  assign o_Cpu_Rst   = rst_q;
  assign o_Running   = run_q;
  assign o_Halted_Bp = bp_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the 8-bit CPU on the Go board. It replaces the free-running `clk_div` tap with a single-cycle clock enable, `o_Cpu_Ce`, on `i_Clk`. It debounces the four board switches and drives run, step, speed select and CPU-reset requests. An optional PC breakpoint halts execution. It sits between the board pins and `computer`, and its status outputs feed the LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: cycles a synchronized switch must stay stable before it is accepted (10 ms at 25 MHz).
- `TICK_DIV_LOG2`, default 22: the slow-speed tick period is 2^TICK_DIV_LOG2 cycles.
- `RST_CYCLES`, default 4: width of the CPU reset pulse.
- `BREAK_EN`, default 0: 1 enables the PC breakpoint.
- `BREAK_PC`, default 8'hFF: breakpoint address.
- `i_Clk`, in, 1: the only clock.
- `i_Rst_L`, in, 1: asynchronous, active-low reset.
- `i_Switch_1`, in, 1: run/halt toggle. Raw input, active-high when pressed.
- `i_Switch_2`, in, 1: single-step request. Raw input.
- `i_Switch_3`, in, 1: speed select level. 0 = slow, 1 = fast.
- `i_Switch_4`, in, 1: CPU reset request. Raw input.
- `i_Pc`, in, 8: CPU program counter, `pc_out_bus`.
- `o_Cpu_Ce`, out, 1: one-cycle clock-enable pulse. The CPU advances one instruction per pulse.
- `o_Cpu_Rst`, out, 1: synchronous reset to the CPU, active-high.
- `o_Running`, out, 1: 1 while in `S_RUN`.
- `o_Halted_Bp`, out, 1: sticky flag, set when the breakpoint caused a halt.

## Operation
- **Switch conditioning.** Each switch passes through a 2-flop synchronizer and then a debouncer.
  - The debounce counter clears on any change of the synchronized level.
  - The debounced level updates when the counter reaches DEBOUNCE_CYCLES-1.
  - A press event is a one-cycle pulse on the debounced rising edge. SW3 is used as a debounced level only.
- **FSM states:** `S_RST`, `S_HALT`, `S_RUN`.
- **`S_RST`:**
  - `o_Cpu_Rst` = 1 and the reset counter counts RST_CYCLES cycles.
  - On completion, go to `S_HALT` with the tick counter cleared.
  - Entered on async reset release and on an SW4 press from any state.
- **`S_HALT`:**
  - SW1 press: go to `S_RUN` and clear `o_Halted_Bp`.
  - SW2 press: one `o_Cpu_Ce` pulse; stay in `S_HALT`.
- **`S_RUN`:**
  - The tick counter increments every cycle. When counter >= period-1, pulse `o_Cpu_Ce` and reset the counter to 0.
  - Period is 2^TICK_DIV_LOG2 when SW3 = 0 and 2^(TICK_DIV_LOG2-2) when SW3 = 1.
  - Because the compare is >=, a speed change mid-count fires on the next cycle if the counter already exceeds the new limit.
  - SW1 press: go to `S_HALT` and clear the counter.
  - SW2 presses are ignored.
- **Breakpoint** (BREAK_EN = 1, in `S_RUN` only):
  - On the cycle after each `o_Cpu_Ce` pulse, compare `i_Pc` with BREAK_PC.
  - On a match: go to `S_HALT` and set `o_Halted_Bp`.
  - On resume, the first tick executes the breakpoint instruction, so the breakpoint does not re-trigger immediately.
- **Priority for same-cycle events:** SW4 > breakpoint > SW1 > SW2.
  - SW1 and SW2 pressed together in `S_HALT`: run wins and no step is taken.

## Timing
- **Async reset** (`i_Rst_L` = 0), effective immediately without a clock:
  - State = `S_RST`; all counters = 0.
  - `o_Cpu_Ce` = 0, `o_Cpu_Rst` = 1, `o_Running` = 0, `o_Halted_Bp` = 0.
- **After release:** `o_Cpu_Rst` stays high for exactly RST_CYCLES `i_Clk` edges, then drops and the state becomes `S_HALT`.
- **Registered outputs:** all outputs are registered. `o_Cpu_Ce` is exactly one cycle wide and never asserts in `S_RST`.
- **Event latency:**
  - Press event at cycle N gives `o_Cpu_Ce`, or the state change, at N+1.
  - Raw switch edge to press event takes 2 + DEBOUNCE_CYCLES cycles.
- **Run ticks:** the first tick comes one period after entering `S_RUN`.
- **Breakpoint:** compare at CE+1 and halt visible at CE+2. No further CE is issued, provided period >= 3.

## Structure
- **Package `cpu_ctrl_pkg`:** FSM state encoding (2 bits) and the speed-shift constant (2).
- **Sub-module `switch_debounce`** (parameter DEBOUNCE_CYCLES):
  - Ports: `i_Clk`, `i_Rst_L`, `i_Raw`, `o_Level`, `o_Press`.
  - Contains the synchronizer; instantiated 4×.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, TICK_DIV_LOG2 = 4, RST_CYCLES = 4.
- **Reset release:** release `i_Rst_L` → `o_Cpu_Rst` high for exactly 4 cycles, then `S_HALT`; no `o_Cpu_Ce` for 100 cycles.
- **Step and debounce:** SW2 held high 10 cycles → exactly one `o_Cpu_Ce`. SW2 glitch of 2 cycles → none.
- **Run and speed:**
  - SW1 press → `o_Cpu_Ce` every 16 cycles and `o_Running` = 1.
  - SW3 high → every 4 cycles.
  - Second SW1 press → no further CE.
- **Breakpoint:** BREAK_EN = 1, BREAK_PC = 5, and a PC model that increments per CE from 0.
  - Run → halt after the 5th CE with `o_Halted_Bp` = 1 and `o_Running` = 0.
  - SW1 press → resumes and the flag clears.
- **CPU reset request:**
  - SW4 press mid-run → 4-cycle `o_Cpu_Rst`, `S_HALT`, and the tick counter restarts from 0 on the next run.
  - SW1 and SW4 pressed together → reset wins.
- **Async reset mid-run:** `i_Rst_L` dropped between clock edges → `o_Cpu_Ce` = 0 and `o_Cpu_Rst` = 1 immediately.
